// File: rtl/frame_stream_packer.sv
// -----------------------------------------------------------------------------
// frame_stream_packer
//
// Purpose
//   Upstream stage of frame_sampler. Accepts a raster pixel stream over a
//   valid/ready handshake, converts each pixel to a fixed-point word and packs
//   it into a flattened INPUT_COUNT-word frame buffer. The completed frame is
//   presented with frame_valid and held stable until frame_ack releases it.
//   Short frames (pix_last early) are zero-padded; long frames (no pix_last on
//   the final word) are truncated. Both raise frame_err for the held frame.
//
// Configuration
//   FRAME_PACKER_CENTER_EN  when defined, pixels are zero-centred before the
//                           shift: conv(p) = sext(p - 2**(PIXEL_WIDTH-1)) << FRAC_BITS.
//                           When undefined: conv(p) = zext(p) << FRAC_BITS.
//
// Ports
//   clk          in   clock, all logic on posedge
//   rst_n        in   synchronous active-low reset
//   pix_valid    in   pixel present
//   pix_ready    out  packer accepts a pixel this cycle (state == FILL)
//   pix_data     in   unsigned pixel, PIXEL_WIDTH bits
//   pix_last     in   marks the final pixel of a frame
//   frame_flat   out  word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   frame_valid  out  frame complete and stable
//   frame_ack    in   consumer releases the held frame (1-cycle pulse)
//   frame_err    out  held frame had a length error; valid with frame_valid
//   frame_count  out  completed frames, wraps 0xFFFF -> 0
//   state_dbg    out  current FSM state (0 FILL, 1 PAD, 2 FULL) for checkers
//
// Handshake: a pixel transfers on any posedge where pix_valid && pix_ready.
// pix_ready does not depend on pix_valid, and pixels offered while pix_ready
// is low are not captured; the source must hold them until accepted.
// -----------------------------------------------------------------------------
module frame_stream_packer #(
    parameter int INPUT_COUNT = 784,
    parameter int PIXEL_WIDTH = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BITS   = 7
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              pix_valid,
    output logic                              pix_ready,
    input  logic [PIXEL_WIDTH-1:0]            pix_data,
    input  logic                              pix_last,
    output logic [DATA_WIDTH*INPUT_COUNT-1:0] frame_flat,
    output logic                              frame_valid,
    input  logic                              frame_ack,
    output logic                              frame_err,
    output logic [15:0]                       frame_count,
    output logic [1:0]                        state_dbg
);

    localparam int IDX_W = (INPUT_COUNT > 1) ? $clog2(INPUT_COUNT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_COUNT - 1);

    // The shifted pixel must fit below the sign bit of a data word.
    if (PIXEL_WIDTH + FRAC_BITS > DATA_WIDTH - 1) begin : g_width_check
        $error("frame_stream_packer: PIXEL_WIDTH+FRAC_BITS must be <= DATA_WIDTH-1");
    end

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_PAD  = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] wr_idx;
    logic [DATA_WIDTH-1:0] pix_word;
    logic             accept;
    logic             at_last_idx;

    assign pix_ready   = (state == ST_FILL);
    assign accept      = pix_valid & pix_ready;
    assign at_last_idx = (wr_idx == LAST_IDX);
    assign state_dbg   = state;

`ifdef FRAME_PACKER_CENTER_EN
    // Subtracting 2**(PIXEL_WIDTH-1) from an unsigned pixel is the same as
    // flipping its MSB and reading the result as two's complement.
    logic [PIXEL_WIDTH-1:0] centered;
    assign centered = pix_data ^ {1'b1, {(PIXEL_WIDTH-1){1'b0}}};
    assign pix_word = {{(DATA_WIDTH-PIXEL_WIDTH){centered[PIXEL_WIDTH-1]}}, centered} << FRAC_BITS;
`else
    assign pix_word = {{(DATA_WIDTH-PIXEL_WIDTH){1'b0}}, pix_data} << FRAC_BITS;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_FILL;
            wr_idx      <= '0;
            frame_flat  <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            frame_count <= '0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (accept) begin
                        frame_flat[wr_idx*DATA_WIDTH +: DATA_WIDTH] <= pix_word;
                        if (at_last_idx) begin
                            // Buffer full: a missing pix_last means the source
                            // sent too many pixels; the extras start the next frame.
                            state       <= ST_FULL;
                            frame_valid <= 1'b1;
                            frame_err   <= ~pix_last;
                            frame_count <= frame_count + 16'd1;
                        end else begin
                            wr_idx <= wr_idx + 1'b1;
                            if (pix_last) begin
                                state     <= ST_PAD;
                                frame_err <= 1'b1;
                            end
                        end
                    end
                end

                ST_PAD: begin
                    // Zero one remaining slot per cycle so no stale words leak
                    // from the previous frame into a short one.
                    frame_flat[wr_idx*DATA_WIDTH +: DATA_WIDTH] <= '0;
                    if (at_last_idx) begin
                        state       <= ST_FULL;
                        frame_valid <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                    end else begin
                        wr_idx <= wr_idx + 1'b1;
                    end
                end

                ST_FULL: begin
                    // Old words stay in frame_flat until overwritten by the next frame.
                    if (frame_ack) begin
                        state       <= ST_FILL;
                        wr_idx      <= '0;
                        frame_valid <= 1'b0;
                        frame_err   <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_FILL;
                end
            endcase
        end
    end

endmodule
